bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detect path. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on a single serial line with a qualifying valid strobe. Its serial output drives the bit input of the downstream sequence-detector FSM.

---
 rtl/bit_serializer.sv | 215 +++++++++++++++++++++
 tb/tb_bit_serializer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the sequence-detect path. Accepts WIDTH-bit
// words over a valid/ready handshake and emits them MSB-first, one bit per clk,
// on ser_out with a qualifying ser_valid strobe.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (XOR of the accepted word) after the last data bit of every word.
//
// Parameters:
//   WIDTH       data word width in bits (2..32)
//   IDLE_LEVEL  level driven on ser_out whenever ser_valid is 0
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   word_in     parallel word, sampled only on the accept edge
//   word_valid  upstream has a word on word_in
//   word_ready  block can accept a word this cycle (combinational)
//   ser_out     serial data bit, MSB first (registered)
//   ser_valid   ser_out carries a data/parity bit this cycle (registered)
//   busy        a word is in flight (registered)
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef SER_PARITY_EN
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
`else
        ST_SHIFT  = 2'd1
`endif
    } state_t;

`ifdef SER_PARITY_EN
    // Even parity of a data word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shreg_r;
    logic [WIDTH-1:0]   shreg_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
`ifdef SER_PARITY_EN
    logic               par_r;
    logic               par_s;
`endif
    logic               ser_out_r;
    logic               ser_out_s;
    logic               ser_valid_r;
    logic               ser_valid_s;
    logic               busy_r;
    logic               busy_s;
    logic               ready_s;
    logic               last_bit_s;
    logic               accept_s;

    // Handshake decode: ready depends only on state, counter and reset.
    always_comb begin
        ready_s    = 1'b0;
        last_bit_s = (state_r == ST_SHIFT) && (cnt_r == LAST_CNT);
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   ready_s = 1'b1;
`ifdef SER_PARITY_EN
                // With parity the next word is taken while the parity bit is out.
                ST_SHIFT:  ready_s = 1'b0;
                ST_PARITY: ready_s = 1'b1;
`else
                // Taking the next word on the last bit gives gap-free frames.
                ST_SHIFT:  ready_s = last_bit_s;
`endif
                default:   ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s   = word_valid & ready_s;
    assign word_ready = ready_s;

    // Next-state, shift register and counter update.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
`ifdef SER_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    shreg_s = word_in;
                    cnt_s   = CNT_ZERO;
`ifdef SER_PARITY_EN
                    par_s   = even_parity(word_in);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
`ifdef SER_PARITY_EN
                    state_s = ST_PARITY;
`else
                    if (accept_s) begin
                        state_s = ST_SHIFT;
                        shreg_s = word_in;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
`endif
                end else begin
                    shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    shreg_s = word_in;
                    cnt_s   = CNT_ZERO;
                    par_s   = even_parity(word_in);
                end else begin
                    state_s = ST_IDLE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                shreg_s = {WIDTH{1'b0}};
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // serial outputs can be registered without adding a cycle of latency.
    always_comb begin
        ser_valid_s = (state_s != ST_IDLE);
        busy_s      = (state_s != ST_IDLE);
        case (state_s)
            ST_SHIFT:  ser_out_s = shreg_s[WIDTH-1];
`ifdef SER_PARITY_EN
            ST_PARITY: ser_out_s = par_s;
`endif
            default:   ser_out_s = IDLE_LEVEL;
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
`ifdef SER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
`ifdef SER_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    // Registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_out_r   <= IDLE_LEVEL;
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ser_out_r   <= ser_out_s;
            ser_valid_r <= ser_valid_s;
            busy_r      <= busy_s;
        end
    end

    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Self-checking bench for bit_serializer (WIDTH=8). A monitor on the falling
// clock edge keeps a scoreboard queue of expected serial bits: accepted words
// are pushed MSB-first (plus an even-parity bit when SER_PARITY_EN is defined)
// and every valid serial cycle pops one bit. Scenario tasks add their own
// inline checks on handshake, reset and stream history.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk;
    logic         rst;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;

    int           tests_run;
    int           fails;
    logic         sb[$];
    int           bits_seen;
    int           run_len;
    int           max_run;
    logic [31:0]  rx_hist;

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare current output, then record a pending accept.
    always @(negedge clk) begin
        logic exp_bit;
        logic exp_ready;
        if (rst) begin
            tests_run++;
            if (ser_valid !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
                fails++;
                $display("FAIL mon_reset: valid=%b busy=%b ready=%b, required 0 0 0",
                         ser_valid, busy, word_ready);
            end
            sb.delete();
            run_len = 0;
        end else begin
            exp_ready = (sb.size() <= 1);
            tests_run++;
            if (word_ready !== exp_ready) begin
                fails++;
                $display("FAIL mon_ready: word_ready=%b, required %b (queued bits %0d)",
                         word_ready, exp_ready, sb.size());
            end
            if (sb.size() > 0) begin
                exp_bit = sb.pop_front();
                tests_run++;
                if (ser_valid !== 1'b1 || ser_out !== exp_bit || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL mon_bit: valid=%b out=%b busy=%b, required 1 %b 1",
                             ser_valid, ser_out, busy, exp_bit);
                end
                bits_seen++;
                rx_hist = {rx_hist[30:0], ser_out};
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                tests_run++;
                if (ser_valid !== 1'b0 || ser_out !== IDLE || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL mon_idle: valid=%b out=%b busy=%b, required 0 %b 0",
                             ser_valid, ser_out, busy, IDLE);
                end
                run_len = 0;
            end
            if (word_valid === 1'b1 && word_ready === 1'b1) begin
                for (int i = W - 1; i >= 0; i--) sb.push_back(word_in[i]);
`ifdef SER_PARITY_EN
                sb.push_back(^word_in);
`endif
            end
        end
    end

    // Present a word and wait (bounded) for it to be accepted; returns at posedge+1.
    task automatic drive_word(input logic [W-1:0] w, input bit hold);
        bit got;
        got        = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: word %h not accepted, required accept within 40 cycles", w);
        end
        @(posedge clk);
        #1;
        if (!hold) word_valid = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then idle a few cycles.
    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout: %0d bits still pending, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        #1;
        tests_run++;
        if (ser_valid !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 || ser_out !== IDLE) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b ready=%b out=%b, required 0 0 0 %b",
                     ser_valid, busy, word_ready, ser_out, IDLE);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (word_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: word_ready=%b, required 1", word_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        int start_bits;
        start_bits = bits_seen;
        drive_word(8'hA5, 1'b0);
        wait_drain();
        tests_run++;
        if (rx_hist[7:0] !== 8'hA5) begin
            fails++;
            $display("FAIL single_stream: got %h, required a5", rx_hist[7:0]);
        end
`ifndef SER_PARITY_EN
        tests_run++;
        if (bits_seen - start_bits != 8) begin
            fails++;
            $display("FAIL single_len: %0d bits, required 8", bits_seen - start_bits);
        end
`endif
        tests_run++;
        if (ser_valid !== 1'b0 || ser_out !== IDLE || word_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_idle: valid=%b out=%b ready=%b, required 0 %b 1",
                     ser_valid, ser_out, word_ready, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        max_run = 0;
        drive_word(8'hFF, 1'b1);
        drive_word(8'h00, 1'b0);
        wait_drain();
`ifndef SER_PARITY_EN
        tests_run++;
        if (max_run != 16) begin
            fails++;
            $display("FAIL b2b_contiguous: run of %0d valid cycles, required 16", max_run);
        end
        tests_run++;
        if (rx_hist[15:0] !== 16'hFF00) begin
            fails++;
            $display("FAIL b2b_stream: got %h, required ff00", rx_hist[15:0]);
        end
`endif
    endtask

    task automatic test_input_stability();
        drive_word(8'hA5, 1'b0);
        @(posedge clk);
        #1;
        word_in = 8'h3C;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || word_ready !== 1'b0) begin
            fails++;
            $display("FAIL stable_midword: busy=%b ready=%b, required 1 0", busy, word_ready);
        end
        drive_word(8'h3C, 1'b0);
        wait_drain();
`ifndef SER_PARITY_EN
        tests_run++;
        if (rx_hist[15:0] !== 16'hA53C) begin
            fails++;
            $display("FAIL stable_stream: got %h, required a53c", rx_hist[15:0]);
        end
`endif
    endtask

    task automatic test_reset_midword();
        int start_bits;
        drive_word(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_out !== IDLE || word_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: valid=%b busy=%b out=%b ready=%b, required 0 0 %b 0",
                     ser_valid, busy, ser_out, word_ready, IDLE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (word_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: word_ready=%b, required 1", word_ready);
        end
        start_bits = bits_seen;
        repeat (12) @(posedge clk);
        #1;
        tests_run++;
        if (bits_seen != start_bits || sb.size() != 0) begin
            fails++;
            $display("FAIL reset_residual: %0d bits after release, required 0", bits_seen - start_bits);
        end
    endtask

    task automatic test_reset_handshake();
        rst        = 1'b1;
        word_in    = 8'hC3;
        word_valid = 1'b1;
        #2;
        tests_run++;
        if (word_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_hs_ready: word_ready=%b, required 0", word_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_hs_accept: busy=%b, required 0", busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || ser_valid !== 1'b1 || ser_out !== 1'b1) begin
            fails++;
            $display("FAIL rst_hs_first_edge: busy=%b valid=%b out=%b, required 1 1 1",
                     busy, ser_valid, ser_out);
        end
        wait_drain();
        tests_run++;
        if (rx_hist[7:0] !== 8'hC3) begin
            fails++;
            $display("FAIL rst_hs_stream: got %h, required c3", rx_hist[7:0]);
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        max_run = 0;
        drive_word(8'hA5, 1'b1);
        drive_word(8'h07, 1'b0);
        wait_drain();
        tests_run++;
        if (max_run != 18) begin
            fails++;
            $display("FAIL parity_contiguous: run of %0d valid cycles, required 18", max_run);
        end
        tests_run++;
        if (rx_hist[17:0] !== {8'hA5, 1'b0, 8'h07, 1'b1}) begin
            fails++;
            $display("FAIL parity_stream: got %h, required %h", rx_hist[17:0],
                     {8'hA5, 1'b0, 8'h07, 1'b1});
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        fails     = 0;
        bits_seen = 0;
        run_len   = 0;
        max_run   = 0;
        rx_hist   = 32'h0000_0000;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_input_stability();
        test_reset_midword();
        test_reset_handshake();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
